// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RV32I load/store engine between execute and data memory
module load_store_unit #(
   parameter int ADDR_W = 32,
   parameter int XLEN   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              resp_fault,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read,
   output logic              mem_write,
   output logic [3:0]        mem_be,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_ready,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t state, state_n;
   logic we_q;
   logic [2:0] f3_q;
   logic [1:0] off_q;
   logic illegal, misal, fault;
   logic [3:0] be_n;
   logic [XLEN-1:0] wd_n, ext;
   logic [7:0] lane_b;
   logic [15:0] lane_h;
   // request decode (fault, byte enables, replicated store data) and load lane extraction
   always_comb begin
      illegal = req_we ? (req_funct3[2] || req_funct3[1:0] == 2'b11)
                       : (req_funct3[1:0] == 2'b11 || req_funct3[2:1] == 2'b11);
      misal   = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
      fault   = illegal || misal;
      be_n    = req_funct3[1:0] == 2'b00 ? 4'b0001 << req_addr[1:0] :
                req_funct3[1:0] == 2'b01 ? 4'b0011 << {req_addr[1], 1'b0} : 4'b1111;
      wd_n    = req_funct3[1:0] == 2'b00 ? {4{req_wdata[7:0]}} :
                req_funct3[1:0] == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
      lane_b  = mem_rdata[{off_q, 3'b000} +: 8];
      lane_h  = mem_rdata[{off_q[1], 4'b0000} +: 16];
      ext     = f3_q == 3'b000 ? {{24{lane_b[7]}}, lane_b} :
                f3_q == 3'b100 ? {24'b0, lane_b} :
                f3_q == 3'b001 ? {{16{lane_h[15]}}, lane_h} :
                f3_q == 3'b101 ? {16'b0, lane_h} : mem_rdata;
   end
   // state register
   always_ff @(posedge clk) begin
      state <= reset ? IDLE : state_n;
   end
   // next state and handshake outputs
   always_comb begin
      state_n    = state;
      req_ready  = 1'b0;
      busy       = 1'b1;
      resp_valid = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      case (state)
         IDLE: begin
            req_ready = !reset;
            busy      = 1'b0;
            if (req_valid) state_n = fault ? RESP : ISSUE;
         end
         ISSUE: begin
            mem_read  = !we_q;
            mem_write = we_q;
            if (mem_ready) state_n = we_q ? RESP : WAIT;
         end
         WAIT: if (mem_rvalid) state_n = RESP;
         RESP: begin
            resp_valid = 1'b1;
            state_n    = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   // latch the request at acceptance and the response when entering RESP
   always_ff @(posedge clk) begin
      if (reset) begin
         we_q       <= 1'b0;
         f3_q       <= 3'b0;
         off_q      <= 2'b0;
         mem_addr   <= '0;
         mem_be     <= 4'b0;
         mem_wdata  <= '0;
         resp_rdata <= '0;
         resp_fault <= 1'b0;
      end else begin
         if (state == IDLE && req_valid) begin
            we_q      <= req_we;
            f3_q      <= req_funct3;
            off_q     <= req_addr[1:0];
            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            mem_be    <= req_we ? be_n : 4'b0;
            mem_wdata <= wd_n;
            if (fault) begin
               resp_fault <= 1'b1;
               resp_rdata <= '0;
            end
         end
         if (state == ISSUE && mem_ready && we_q) begin
            resp_fault <= 1'b0;
            resp_rdata <= '0;
         end
         if (state == WAIT && mem_rvalid) begin
            resp_fault <= 1'b0;
            resp_rdata <= ext;
         end
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit against a transaction-level model
module tb_load_store_unit;
   logic clk = 0, reset;
   logic req_valid, req_ready, req_we;
   logic [2:0] req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic resp_valid, resp_fault, busy;
   logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
   logic mem_read, mem_write, mem_ready, mem_rvalid;
   logic [3:0] mem_be;
   int checks = 0, errors = 0, n_resp = 0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .resp_fault(resp_fault), .busy(busy), .mem_addr(mem_addr),
      .mem_read(mem_read), .mem_write(mem_write), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic mdl_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
      int unsigned size;
      logic legal;
      legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      if (!legal) return 1'b1;
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      return (a % size) != 0;
   endfunction

   function automatic logic [31:0] mdl_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
      logic [31:0] v, b, h;
      v = w >> (8 * (a % 4));
      b = v & 32'd255;
      h = v & 32'd65535;
      case (f3)
         3'd0: return b >= 128 ? b + 32'hFFFFFF00 : b;
         3'd4: return b;
         3'd1: return h >= 32768 ? h + 32'hFFFF0000 : h;
         3'd5: return h;
         default: return w;
      endcase
   endfunction

   function automatic logic [3:0] mdl_be(input logic [2:0] f3, input logic [31:0] a);
      int unsigned s;
      s = 1 << (a % 4);
      if (f3 == 3'd1) s = 3 << (a % 4);
      if (f3 == 3'd2) s = 15;
      return s[3:0];
   endfunction

   function automatic logic [31:0] mdl_wd(input logic [2:0] f3, input logic [31:0] w);
      return f3 == 3'd0 ? (w & 32'd255) * 32'h01010101 :
             f3 == 3'd1 ? (w & 32'd65535) * 32'h00010001 : w;
   endfunction

   typedef enum {M_IDLE, M_ISSUE, M_WAIT, M_RESP} mph_t;
   mph_t ph = M_IDLE;
   logic armed = 0, t_we = 0, e_fault = 0;
   logic [2:0] t_f3 = 0;
   logic [31:0] t_addr = 0, t_wd = 0, e_rdata = 0;

   // transaction model: what the unit owes the outside world given the inputs seen so far
   always @(posedge clk) begin
      if (reset) begin
         ph <= M_IDLE;
         armed <= 1;
      end else begin
         case (ph)
            M_IDLE: if (req_valid) begin
               t_we <= req_we; t_f3 <= req_funct3; t_addr <= req_addr; t_wd <= req_wdata;
               if (mdl_fault(req_we, req_funct3, req_addr)) begin
                  e_fault <= 1; e_rdata <= 0; ph <= M_RESP;
               end else ph <= M_ISSUE;
            end
            M_ISSUE: if (mem_ready) begin
               if (t_we) begin e_fault <= 0; e_rdata <= 0; ph <= M_RESP; end
               else ph <= M_WAIT;
            end
            M_WAIT: if (mem_rvalid) begin
               e_fault <= 0; e_rdata <= mdl_load(t_f3, t_addr, mem_rdata); ph <= M_RESP;
            end
            default: ph <= M_IDLE;
         endcase
      end
   end

   // per-cycle comparison of every DUT output against the model
   always @(negedge clk) begin
      if (armed) begin
         if (resp_valid) n_resp++;
         chk("req_ready", req_ready, ph == M_IDLE && !reset);
         chk("busy", busy, ph != M_IDLE);
         chk("resp_valid", resp_valid, ph == M_RESP);
         chk("mem_read", mem_read, ph == M_ISSUE && !t_we);
         chk("mem_write", mem_write, ph == M_ISSUE && t_we);
         if (ph == M_RESP) begin
            chk("resp_rdata", resp_rdata, e_rdata);
            chk("resp_fault", resp_fault, e_fault);
         end
         if (ph == M_ISSUE) begin
            chk("mem_addr", mem_addr, t_addr & ~32'd3);
            chk("mem_be", mem_be, t_we ? mdl_be(t_f3, t_addr) : 4'b0);
            if (t_we) chk("mem_wdata", mem_wdata, mdl_wd(t_f3, t_wd));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                      input int stall, input logic [31:0] rd, output int lat, output logic [31:0] rdat,
                      output logic flt, output logic saw, output logic [31:0] ma, output logic [3:0] mbe,
                      output logic [31:0] mwd, output logic stable, output logic rdy);
      int n = 0;
      lat = 1; rdat = 0; flt = 0; saw = 0; ma = 0; mbe = 0; mwd = 0; stable = 1; rdy = 0;
      req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      step();
      req_valid = 0;
      while (lat < 40) begin
         mem_ready = 0; mem_rvalid = 0;
         if (resp_valid) begin
            rdat = resp_rdata; flt = resp_fault;
            break;
         end
         if (req_ready) rdy = 1;
         if (mem_read || mem_write) begin
            if (!saw) begin ma = mem_addr; mbe = mem_be; mwd = mem_wdata; end
            else if ({ma, mbe, mwd} !== {mem_addr, mem_be, mem_wdata}) stable = 0;
            saw = 1;
            mem_ready = n >= stall;
            n++;
         end else if (busy) begin
            mem_rvalid = 1; mem_rdata = rd;
         end
         step();
         lat++;
      end
      mem_ready = 0; mem_rvalid = 0;
      step();
   endtask

   int lat;
   logic [31:0] rdat, ma, mwd;
   logic flt, saw, stable, rdy, late;
   logic [3:0] mbe;

   initial begin
      reset = 1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
      mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
      step(); step();
      chk("reset_req_ready", req_ready, 0);
      reset = 0;
      step();
      chk("post_reset_req_ready", req_ready, 1);
      chk("reset_busy", busy, 0);
      chk("reset_mem_addr", mem_addr, 0);
      chk("reset_mem_be", mem_be, 0);
      chk("reset_mem_wdata", mem_wdata, 0);
      chk("reset_resp_rdata", resp_rdata, 0);
      chk("reset_mem_access", {mem_read, mem_write, resp_valid, resp_fault}, 0);

      txn(0, 3'b010, 32'h100, 0, 0, 32'hDEADBEEF, lat, rdat, flt, saw, ma, mbe, mwd, stable, rdy);
      chk("lw_latency", lat, 3); chk("lw_rdata", rdat, 32'hDEADBEEF);
      chk("lw_fault", flt, 0); chk("lw_addr", ma, 32'h100); chk("lw_be", mbe, 0);
      txn(0, 3'b000, 32'h103, 0, 0, 32'h80FF0000, lat, rdat, flt, saw, ma, mbe, mwd, stable, rdy);
      chk("lb_rdata", rdat, 32'hFFFFFF80); chk("lb_addr", ma, 32'h100);
      txn(0, 3'b100, 32'h103, 0, 0, 32'h80FF0000, lat, rdat, flt, saw, ma, mbe, mwd, stable, rdy);
      chk("lbu_rdata", rdat, 32'h00000080);
      txn(0, 3'b101, 32'h102, 0, 0, 32'h80FF0000, lat, rdat, flt, saw, ma, mbe, mwd, stable, rdy);
      chk("lhu_rdata", rdat, 32'h000080FF);
      txn(1, 3'b000, 32'h201, 32'h000000A5, 0, 0, lat, rdat, flt, saw, ma, mbe, mwd, stable, rdy);
      chk("sb_be", mbe, 4'b0010); chk("sb_wdata", mwd, 32'hA5A5A5A5);
      chk("sb_addr", ma, 32'h200); chk("sb_latency", lat, 2); chk("sb_rdata", rdat, 0);
      txn(1, 3'b001, 32'h202, 32'h1234BEEF, 3, 0, lat, rdat, flt, saw, ma, mbe, mwd, stable, rdy);
      chk("sh_be", mbe, 4'b1100); chk("sh_wdata", mwd, 32'hBEEFBEEF);
      chk("sh_stable", stable, 1); chk("sh_latency", lat, 5); chk("sh_req_ready_low", rdy, 0);
      txn(0, 3'b010, 32'h102, 0, 0, 32'h12345678, lat, rdat, flt, saw, ma, mbe, mwd, stable, rdy);
      chk("lw_mis_fault", flt, 1); chk("lw_mis_latency", lat, 1); chk("lw_mis_noaccess", saw, 0);
      txn(1, 3'b001, 32'h301, 32'hFFFF, 0, 0, lat, rdat, flt, saw, ma, mbe, mwd, stable, rdy);
      chk("sh_mis_fault", flt, 1); chk("sh_mis_latency", lat, 1); chk("sh_mis_noaccess", saw, 0);
      chk("sh_mis_rdata", rdat, 0);

      req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h180;
      step();
      req_valid = 0; mem_ready = 1;
      step();
      mem_ready = 0;
      chk("wait_busy", busy, 1);
      chk("wait_no_read", mem_read, 0);
      reset = 1;
      #1 chk("mid_reset_req_ready", req_ready, 0);
      step();
      reset = 0;
      late = 0;
      for (int i = 0; i < 3; i++) begin
         mem_rvalid = 1; mem_rdata = $urandom;
         if (resp_valid || busy) late = 1;
         step();
      end
      mem_rvalid = 0;
      chk("late_rvalid_dropped", late, 0);
      txn(0, 3'b010, 32'h104, 0, 1, 32'h13579BDF, lat, rdat, flt, saw, ma, mbe, mwd, stable, rdy);
      chk("post_reset_lw_rdata", rdat, 32'h13579BDF); chk("post_reset_lw_latency", lat, 4);

      for (int c = 0; c < 4000; c++) begin
         reset = $urandom_range(0, 199) == 0;
         req_valid = $urandom_range(0, 1) == 1;
         req_we = $urandom_range(0, 1) == 1;
         req_funct3 = 3'($urandom_range(0, 7));
         req_addr = $urandom;
         req_wdata = $urandom;
         mem_ready = $urandom_range(0, 2) != 0;
         mem_rvalid = $urandom_range(0, 1) == 1;
         mem_rdata = $urandom;
         step();
      end
      reset = 0; req_valid = 0; mem_ready = 1; mem_rvalid = 1;
      repeat (6) step();
      mem_ready = 0; mem_rvalid = 0;
      step();
      chk("random_responses_seen", n_resp > 300, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and data_memory.
- Accepts one load/store request at a time over a valid/ready handshake.
- Checks alignment, generates byte enables and replicated store data, and drives a handshaked memory port.
- Extracts and sign/zero-extends load data, then returns a single-cycle response to writeback.

Parameters:
ADDR_W, 32, byte address width of req_addr and mem_addr
XLEN, 32, data width (fixed 32; 4 byte lanes)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  execute presents a request
req_ready  output  1  LSU can accept; high only in IDLE
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  input  ADDR_W  byte address
req_wdata  input  XLEN  store data (rs2)
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  XLEN  extended load data; 0 for stores and faults
resp_fault  output  1  misaligned or illegal funct3; valid with resp_valid
busy  output  1  state != IDLE
mem_addr  output  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
mem_read  output  1  read request
mem_write  output  1  write request
mem_be  output  4  byte enables (writes only; 4'b0000 on reads)
mem_wdata  output  XLEN  lane-replicated store data
mem_ready  input  1  memory accepts current request this cycle
mem_rvalid  input  1  read data valid
mem_rdata  input  XLEN  read word

Behaviour:
- Reset values:
  - state = IDLE; resp_valid, resp_fault, mem_read, mem_write, busy = 0.
  - resp_rdata, mem_addr, mem_wdata, mem_be = 0.
  - req_ready = 0 during the reset cycle and 1 from the first cycle after.
- States:
  - IDLE: req_ready = 1.
    - On req_valid, latch we/funct3/addr/wdata.
    - Fault -> RESP; otherwise -> ISSUE.
  - ISSUE: mem_read (load) or mem_write (store) asserted with address/be/wdata held stable until mem_ready.
    - On mem_ready: store -> RESP; load -> WAIT.
  - WAIT: on mem_rvalid, capture extracted data -> RESP.
  - RESP: resp_valid = 1 for exactly one cycle -> IDLE.
    - No new request is accepted in RESP.
- Fault rules:
  - LH/LHU/SH with addr[0] = 1.
  - LW/SW with addr[1:0] != 0.
  - Load funct3 011/110/111.
  - Store funct3 other than 000/001/010.
  - A fault performs no memory access.
- Store lanes:
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: be = 4'b0011 << {addr[1],1'b0}; wdata = {2{wdata[15:0]}}.
  - SW: be = 4'b1111.
- Load extraction:
  - Byte = mem_rdata >> (8*addr[1:0]).
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend.
  - LW passes the full word.
- Latency, counting request acceptance as cycle 0:
  - Fault: resp_valid in cycle 1.
  - Store: ISSUE in cycle 1; mem_ready in cycle 1 gives resp in cycle 2.
  - Load: mem_ready in cycle 1 and mem_rvalid in cycle 2 give resp in cycle 3.
  - Each extra stall cycle adds one cycle.
- Memory timing:
  - mem_rvalid is honoured only in WAIT, at the earliest the cycle after the mem_ready handshake.
  - mem_rvalid in any other state is ignored.
- Reset mid-operation: the transaction is abandoned.
  - mem_read/mem_write deassert the next cycle.
  - A late mem_rvalid arriving in IDLE is dropped.
  - No resp_valid is generated.
- resp_rdata and resp_fault hold their last value outside RESP (don't-care to consumers).

Test Plan:
- LW addr 0x100, mem_rdata 0xDEADBEEF, mem_ready immediate, rvalid next cycle -> resp_valid in cycle 3, resp_rdata 0xDEADBEEF, fault 0, mem_addr 0x100.
- LB addr 0x103, mem_rdata 0x80FF0000 -> resp_rdata 0xFFFFFF80; LBU at the same address -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
- SB addr 0x201, wdata 0x000000A5 -> mem_be 4'b0010, mem_wdata 0xA5A5A5A5, mem_addr 0x200, resp in cycle 2 with rdata 0.
- SH addr 0x202 with mem_ready low for 3 cycles -> mem_write, be 4'b1100 and wdata 0xXXXX replicated all held stable; resp 3 cycles later; req_ready low throughout.
- LW addr 0x102 and SH addr 0x301 -> resp_fault 1 in cycle 1; mem_read/mem_write never asserted.
- Reset asserted while in WAIT, then mem_rvalid pulses in IDLE -> no resp_valid; next LW completes normally with correct data.
